// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: serial CHUNK-wide popcount of a parallel
// bitstream, then inverse SNG quota mapping to a signed QUANT-bit value.
module sc_bitstream_decoder #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CHUNK     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BITSTREAM-1:0]         in_bits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [QUANT-1:0]             out_data,
  output logic [$clog2(BITSTREAM):0]   out_count
);

  localparam int NCHUNK = BITSTREAM / CHUNK;
  localparam int CW     = $clog2(BITSTREAM) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PW     = $clog2(CHUNK) + 1;
  localparam int LG     = $clog2(BITSTREAM);
  localparam int UW     = CW + QUANT + 1;
  localparam int UMAX   = (1 << QUANT) - 1;
  localparam int BIAS   = 1 << (QUANT - 1);

  if ((BITSTREAM % CHUNK) != 0) begin : g_chk_div
    $fatal(1, "BITSTREAM must be a multiple of CHUNK");
  end
  if ((BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_chk_pow2
    $fatal(1, "BITSTREAM must be a power of two");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [BITSTREAM-1:0] r_shreg;
  logic [CW-1:0]        r_acc;
  logic [IW-1:0]        r_idx;
  logic [PW-1:0]        w_pop;
  logic [CW-1:0]        w_total;
  logic [UW-1:0]        w_u_raw;
  logic [UW-1:0]        w_u_sat;
  logic [QUANT-1:0]     w_data;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_idx == IW'(NCHUNK - 1));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_pop = w_pop + PW'(r_shreg[i]);
    end
  end

  // Round-to-nearest rescale of count onto the 2^QUANT code space
  always_comb begin
    w_total = r_acc + CW'(w_pop);
    w_u_raw = ((UW'(w_total) << QUANT) + UW'(BITSTREAM / 2)) >> LG;
    w_u_sat = (w_u_raw > UW'(UMAX)) ? UW'(UMAX) : w_u_raw;
    w_data  = QUANT'(w_u_sat - UW'(BIAS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_COUNT;
      S_COUNT: if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (w_accept) begin
      r_shreg <= in_bits;
      r_acc   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_COUNT) begin
      r_shreg <= r_shreg >> CHUNK;
      r_acc   <= w_total;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        out_count <= w_total;
        out_data  <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Self-checking bench for sc_bitstream_decoder against a count-based
// reference model of the decode rule.
module tb_sc_bitstream_decoder;

  localparam int BS  = 64;
  localparam int Q   = 8;
  localparam int CH  = 8;
  localparam int NCH = BS / CH;
  localparam int CW  = $clog2(BS) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BS-1:0] in_bits = '0;
  logic          in_ready;
  logic          out_valid;
  logic [Q-1:0]  out_data;
  logic [CW-1:0] out_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_bitstream_decoder #(
    .BITSTREAM(BS),
    .QUANT(Q),
    .CHUNK(CH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
  );

  function automatic logic [BS-1:0] ones_pattern(int n);
    logic [BS-1:0] v;
    int j;
    logic t;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    for (int i = BS - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = v[i];
      v[i] = v[j];
      v[j] = t;
    end
    return v;
  endfunction

  function automatic logic [BS-1:0] rnd_bits();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [Q-1:0] exp_data(int c);
    int u;
    u = (c * (2 ** Q) + BS / 2) / BS;
    if (u > 2 ** Q - 1) u = 2 ** Q - 1;
    return Q'(u - 2 ** (Q - 1));
  endfunction

  task automatic send(input logic [BS-1:0] b, output int lat,
                      output bit rdy_low);
    in_bits  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_low = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
    n_chk++;
    if (out_data !== '0 || out_count !== '0) begin
      n_err++;
      $display("FAIL reset_data: data=%h count=%0d want 0/0",
               out_data, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_patterns();
    int cnts[8];
    int lat;
    bit rl;
    logic [BS-1:0] b;
    cnts = '{0, 16, 32, 48, 64, 1, 63, 0};
    cnts[7] = $urandom_range(BS, 0);
    foreach (cnts[k]) begin
      b = ones_pattern(cnts[k]);
      send(b, lat, rl);
      n_chk++;
      if (lat !== NCH || !rl) begin
        n_err++;
        $display("FAIL pat_lat n=%0d: lat=%0d rdy_low=%b want %0d/1",
                 cnts[k], lat, rl, NCH);
      end
      n_chk++;
      if (out_count !== CW'($countones(b))) begin
        n_err++;
        $display("FAIL pat_count: got %0d want %0d",
                 out_count, $countones(b));
      end
      n_chk++;
      if (out_data !== exp_data(cnts[k])) begin
        n_err++;
        $display("FAIL pat_data n=%0d: got %h want %h",
                 cnts[k], out_data, exp_data(cnts[k]));
      end
      release_out();
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL pat_release: out_valid=%b in_ready=%b want 0/1",
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BS-1:0] b;
    logic [Q-1:0] d;
    logic [CW-1:0] c;
    int lat;
    b = ones_pattern(37);
    in_bits  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      in_bits = rnd_bits();
      @(posedge clk); #1;
      lat++;
    end
    d = out_data;
    c = out_count;
    n_chk++;
    if (lat !== NCH || c !== CW'(37) || d !== exp_data(37)) begin
      n_err++;
      $display("FAIL bp_result: lat=%0d count=%0d data=%h want %0d/37/%h",
               lat, c, d, NCH, exp_data(37));
    end
    for (int k = 0; k < 5; k++) begin
      in_bits = rnd_bits();
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== d || out_count !== c) begin
        n_err++;
        $display("FAIL bp_hold %0d: v=%b r=%b data=%h count=%0d want 1/0/%h/%0d",
                 k, out_valid, in_ready, out_data, out_count, d, c);
      end
    end
    in_valid = 1'b0;
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rl;
    in_bits  = ones_pattern(50);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_data !== '0 || out_count !== '0) begin
      n_err++;
      $display("FAIL rst_count: v=%b r=%b data=%h count=%0d want 0/1/0/0",
               out_valid, in_ready, out_data, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NCH + 2) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_no_partial: out_valid=%b want 0", out_valid);
    end
    send(ones_pattern(10), lat, rl);
    n_chk++;
    if (out_count !== CW'(10) || out_data !== 8'hA8 || lat !== NCH) begin
      n_err++;
      $display("FAIL rst_after: count=%0d data=%h lat=%0d want 10/a8/%0d",
               out_count, out_data, lat, NCH);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_count !== '0) begin
      n_err++;
      $display("FAIL rst_done: v=%b count=%0d want 0/0",
               out_valid, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_roundtrip();
    int s;
    int e;
    int lat;
    bit rl;
    int bad;
    bad = 0;
    for (int q = -127; q <= 128; q++) begin
      s = ((q + 128) * BS) / (2 ** Q);
      send(ones_pattern(s), lat, rl);
      e = 4 * s;
      if (e > 255) e = 255;
      n_chk++;
      if (out_data !== Q'(e - 128) || lat !== NCH) begin
        n_err++;
        bad++;
        if (bad < 10)
          $display("FAIL rt q=%0d: data=%h lat=%0d want %h/%0d",
                   q, out_data, lat, Q'(e - 128), NCH);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int lat;
    bit rl;
    logic [BS-1:0] b;
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(BS, 0);
      b = ones_pattern(n);
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready %0d: in_ready=%b want 1", k, in_ready);
      end
      send(b, lat, rl);
      n_chk++;
      if (lat !== NCH || !rl || out_count !== CW'(n) ||
          out_data !== exp_data(n)) begin
        n_err++;
        $display("FAIL b2b %0d: lat=%0d rl=%b count=%0d data=%h want %0d/1/%0d/%h",
                 k, lat, rl, out_count, out_data, NCH, n, exp_data(n));
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
